// File: rtl/priority_encoder_rr_pkg.sv
// priority_encoder_rr_pkg -- shared defaults and mode encodings. Rev 1.0
`default_nettype none

package priority_encoder_rr_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/priority_encoder_rr_prio_scan.sv
// prio_scan -- descending circular search from a start index; first set bit wins. Rev 1.0
`default_nettype none

module prio_scan
  import priority_encoder_rr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int p;
    idx = '0;
    any = 1'b0;
    p   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      // Visit start, start-1, ..., 0, WIDTH-1, ..., start+1.
      p = int'(start) - i;
      if (p < 0) p = p + WIDTH;
      if (!any && din[p]) begin
        any = 1'b1;
        idx = IDX_W'(p);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr -- registered fixed/round-robin priority encoder with valid/ready handshake. Rev 1.0
`default_nettype none

module priority_encoder_rr
  import priority_encoder_rr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] dout,
  output logic             any,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] scan_start;
  logic [IDX_W-1:0] scan_idx;
  logic             scan_any;
  logic             accept;
  logic             rr_sel;

  assign in_ready   = en & (~out_valid | out_ready);
  assign accept     = in_valid & in_ready;
  assign rr_sel     = (mode == MODE_RR);
  assign scan_start = rr_sel ? ptr : TOP_IDX;

  prio_scan #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_scan (
    .din   (din),
    .start (scan_start),
    .idx   (scan_idx),
    .any   (scan_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      any       <= 1'b0;
      out_valid <= 1'b0;
      ptr       <= TOP_IDX;
    end else if (accept) begin
      dout      <= scan_idx;
      any       <= scan_any;
      out_valid <= 1'b1;
      // Next round-robin search begins just below the last winner.
      if (rr_sel && scan_any) begin
        ptr <= (scan_idx == '0) ? TOP_IDX : scan_idx - 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr -- directed vectors with a scoreboard queue and decoupled monitor.
`default_nettype none

module tb_priority_encoder_rr;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [IDX_W-1:0] dout;
    logic             any;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] dout;
  logic             any;
  logic             out_valid;
  logic             out_ready;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  priority_encoder_rr #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .any       (any),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a result is consumed on the edge following a cycle with out_valid && out_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_result: got dout=%0d any=%0d, expected none", dout, any);
        end else begin
          e = exp_q.pop_front();
          chk("result_dout", int'(dout), int'(e.dout));
          chk("result_any", int'(any), int'(e.any));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector that must be accepted this cycle; out_ready stays 1.
  task automatic send(input logic [WIDTH-1:0] d, input logic m,
                      input int ed, input logic ea);
    en = 1'b1; in_valid = 1'b1; din = d; mode = m; out_ready = 1'b1;
    exp_q.push_back('{dout: IDX_W'(ed), any: ea});
    @(negedge clk);
    chk("send_in_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("drained_out_valid", int'(out_valid), 0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; din = '0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_any", int'(any), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    step();
    step();
    rst_n = 1'b1;

    // Fixed priority, highest index wins.
    send(8'b0010_0110, 1'b0, 5, 1'b1);
    // Round-robin from ptr=7.
    send(8'hFF, 1'b1, 7, 1'b1);
    send(8'hFF, 1'b1, 6, 1'b1);
    send(8'hFF, 1'b1, 5, 1'b1);
    send(8'b1000_0001, 1'b1, 0, 1'b1);
    send(8'b1000_0001, 1'b1, 7, 1'b1);
    // All-zero request leaves ptr at 6.
    send(8'h00, 1'b1, 0, 1'b0);
    send(8'hFF, 1'b1, 6, 1'b1);
    drain();

    // Backpressure hold: ptr=5, 0x0F -> 3, ptr becomes 2.
    en = 1'b1; in_valid = 1'b1; din = 8'h0F; mode = 1'b1; out_ready = 1'b1;
    exp_q.push_back('{dout: 3'd3, any: 1'b1});
    step();
    out_ready = 1'b0; din = 8'hF0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_dout", int'(dout), 3);
      step();
    end
    out_ready = 1'b1; din = 8'h80; mode = 1'b0;
    exp_q.push_back('{dout: 3'd7, any: 1'b1});
    @(negedge clk);
    chk("replace_in_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble_out_valid", int'(out_valid), 1);
    step();
    @(negedge clk);
    chk("after_replace_out_valid", int'(out_valid), 0);

    // Enable low: pending result drains, nothing new accepted. ptr=2, 0x04 -> 2, ptr 1.
    en = 1'b1; in_valid = 1'b1; din = 8'h04; mode = 1'b1; out_ready = 1'b1;
    exp_q.push_back('{dout: 3'd2, any: 1'b1});
    step();
    en = 1'b0; din = 8'hFF; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("en_low_in_ready", int'(in_ready), 0);
      chk("en_low_dout_held", int'(dout), 2);
      step();
    end
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("en_low_drained", int'(out_valid), 0);
    step();
    send(8'hFF, 1'b1, 1, 1'b1);
    drain();

    // Reset mid-transaction: ptr=0, 0x02 -> 1, ptr 0; then reset discards it.
    en = 1'b1; in_valid = 1'b1; din = 8'h02; mode = 1'b1; out_ready = 1'b1;
    exp_q.push_back('{dout: 3'd1, any: 1'b1});
    step();
    out_ready = 1'b0; din = 8'hFF;
    #2;
    chk("pre_reset_out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("async_reset_out_valid", int'(out_valid), 0);
    chk("async_reset_dout", int'(dout), 0);
    chk("async_reset_any", int'(any), 0);
    out_ready = 1'b1;
    step();
    chk("no_accept_in_reset", int'(out_valid), 0);
    rst_n = 1'b1;
    send(8'hFF, 1'b1, 7, 1'b1);
    // Fixed-mode grants leave ptr at 6.
    send(8'h01, 1'b0, 0, 1'b1);
    send(8'h00, 1'b0, 0, 1'b0);
    send(8'hFF, 1'b1, 6, 1'b1);
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/priority_encoder_rr.md
PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 Parameter WIDTH, default 8, number of request lines; legal range 2..64.
REQ-002 Parameter IDX_W, default $clog2(WIDTH), width of the encoded index output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  enable; when 0, no new request vector is accepted.
REQ-006 mode  input  1  0 = fixed priority with the highest index winning; 1 = round-robin.
REQ-007 din  input  WIDTH  request vector.
REQ-008 in_valid  input  1  din is valid this cycle.
REQ-009 in_ready  output  1  block can accept din this cycle.
REQ-010 dout  output  IDX_W  registered index of the winning request.
REQ-011 any  output  1  registered flag: the accepted din had at least one bit set.
REQ-012 out_valid  output  1  dout and any hold a result.
REQ-013 out_ready  input  1  downstream consumes the result.

Function
REQ-014 in_ready SHALL equal en AND (NOT out_valid OR out_ready), combinationally.
REQ-015 Acceptance SHALL occur when in_valid AND in_ready; the result SHALL appear on dout/any with out_valid=1 on the next clock edge (latency 1).
REQ-016 Output regs SHALL hold dout/any/out_valid stable while out_valid=1 and out_ready=0.
REQ-017 out_valid SHALL clear when out_ready=1 and no acceptance occurs that cycle.
REQ-018 Acceptance and consumption in the same cycle SHALL replace the result, keeping out_valid=1 (no bubble).
REQ-019 mode SHALL be sampled only at acceptance.
REQ-020 Fixed mode: winner SHALL be the highest set index of din.
REQ-021 Round-robin mode: search SHALL start at pointer ptr and descend with wrap (ptr, ptr-1, ..., 0, WIDTH-1, ..., ptr+1); the first set bit wins.
REQ-022 After a round-robin acceptance with any=1 and winner k, ptr SHALL become k-1, wrapping to WIDTH-1 when k=0.
REQ-023 ptr SHALL NOT change on fixed-mode acceptances, on any=0, or when nothing is accepted.
REQ-024 When din is all zero, the result SHALL be dout=0, any=0, out_valid=1.
REQ-025 en=0 SHALL NOT clear a pending result; the result still drains via out_ready.

Reset
REQ-026 rst_n=0 SHALL immediately force dout=0, any=0, out_valid=0 and ptr=WIDTH-1, including mid-transaction; a pending result SHALL be discarded.
REQ-027 No acceptance SHALL occur on the first edge while rst_n=0; operation SHALL resume on the first edge after deassertion.

Structure
REQ-028 A shared package SHALL hold the default WIDTH and the mode encodings (MODE_FIXED=0, MODE_RR=1).
REQ-029 The combinational scan SHALL be one sub-module, prio_scan (inputs din and start index; outputs index and any), used for both modes (fixed mode uses start=WIDTH-1).
REQ-030 All state (dout, any, out_valid, ptr) SHALL be in a single clocked process.

Verification (WIDTH=8)
REQ-031 Assert rst_n=0 while out_valid=1 -> immediately out_valid=0, dout=0, any=0; next RR grant starts from index 7.
REQ-032 mode=0, din=8'b0010_0110 accepted -> next cycle dout=5, any=1, out_valid=1.
REQ-033 mode=1, din=8'hFF accepted three times with out_ready=1 -> dout 7, 6, 5; then din=8'b1000_0001 -> dout=0; then the same din -> dout=7.
REQ-034 out_ready=0 with out_valid=1 -> in_ready=0, dout held over 5 cycles, new din ignored; raise out_ready together with in_valid -> new result next cycle with no gap in out_valid.
REQ-035 din=8'h00 accepted in mode=1 -> dout=0, any=0, out_valid=1; ptr unchanged (checked by the following grant).
REQ-036 en=0 with in_valid=1 -> in_ready=0, no new result; a pending result still drains when out_ready=1.
